// File: rtl/freq_disp_pkg.sv
// Shared constants and helpers for the frequency counter display path.
package freq_disp_pkg;

  localparam int BCD_W = 4;
  localparam int DEFAULT_NUM_DIGITS = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'd0;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Load/display bundle between the counter core and the digit scanner.
interface digit_scan_mux_if #(
  parameter int NUM_DIGITS = freq_disp_pkg::DEFAULT_NUM_DIGITS
);
  import freq_disp_pkg::*;

  logic                        load;
  logic [BCD_W*NUM_DIGITS-1:0] bcd_in;
  logic [BCD_W-1:0]            bcd_out;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic                        frame_start;

  modport master (
    output load, bcd_in,
    input  bcd_out, digit_en, frame_start
  );

  modport slave (
    input  load, bcd_in,
    output bcd_out, digit_en, frame_start
  );

endinterface

// File: rtl/refresh_prescaler.sv
// Free-running divide-by-DIV counter; tick is high during the last count.
module refresh_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Multiplexed 7-segment digit scanner with frame-aligned double buffering
// and leading-zero blanking.
module digit_scan_mux
  import freq_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  digit_scan_mux_if.slave  bus
);

  localparam int IDX_W   = idx_w(NUM_DIGITS);
  localparam int FRAME_W = BCD_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  tick;
  logic                  wrap;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [FRAME_W-1:0]    disp_q, disp_d;
  logic [NUM_DIGITS-1:0] blank;
  logic [BCD_W-1:0]      cur_code;
  logic [BCD_W-1:0]      bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_start_q, frame_start_d;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // A load on the wrap cycle bypasses pend so it lands in this frame boundary.
  always_comb begin
    wrap     = tick && (idx_q == LAST_IDX);
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    if (bus.load) begin
      pend_d   = bus.bcd_in;
      pend_v_d = 1'b1;
    end
    if (wrap) begin
      if (bus.load) begin
        disp_d   = bus.bcd_in;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end
  end

  // Outputs are built from next-state idx/disp so the registered view
  // already matches the new slot on the edge where it begins.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (disp_d[k*BCD_W +: BCD_W] != BLANK_CODE) zero_above = 1'b0;
      blank[k] = zero_above;
    end
    cur_code      = disp_d[int'(idx_d)*BCD_W +: BCD_W];
    digit_en_d    = '0;
    bcd_out_d     = BLANK_CODE;
    frame_start_d = wrap;
    if (!blank[idx_d]) begin
      digit_en_d[idx_d] = 1'b1;
      bcd_out_d         = cur_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      disp_q        <= '0;
      bcd_out_q     <= BLANK_CODE;
      digit_en_q    <= NUM_DIGITS'(1);
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      disp_q        <= disp_d;
      bcd_out_q     <= bcd_out_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.bcd_out     = bcd_out_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with 4 digits and a refresh divider of 4.
module tb_digit_scan_mux;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  digit_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  digit_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Walks ncyc cycles from the first cycle of a frame, checking every cycle.
  // en_pk/bcd_pk hold the expected per-slot values, slot 0 in bits [3:0].
  task automatic check_frame(input string name, input logic [15:0] en_pk,
                             input logic [15:0] bcd_pk, input logic fs0,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int ncyc);
    logic [3:0] e_en;
    logic [3:0] e_bcd;
    int slot;
    for (int i = 0; i < ncyc; i++) begin
      bus.load = 1'b0;
      if (i == la) begin bus.load = 1'b1; bus.bcd_in = va; end
      if (i == lb) begin bus.load = 1'b1; bus.bcd_in = vb; end
      slot  = i / DIV;
      e_en  = en_pk[slot*4 +: 4];
      e_bcd = bcd_pk[slot*4 +: 4];
      chk($sformatf("%s c%0d en", name, i), 16'(bus.digit_en), 16'(e_en));
      chk($sformatf("%s c%0d bcd", name, i), 16'(bus.bcd_out), 16'(e_bcd));
      chk($sformatf("%s c%0d fs", name, i), 16'(bus.frame_start),
          16'((i == 0) ? fs0 : 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = 16'h0000;
    repeat (2) @(negedge clk);
    bus.load   = 1'b1;
    bus.bcd_in = 16'h7777;
    @(negedge clk);
    chk("reset en", 16'(bus.digit_en), 16'h0001);
    chk("reset bcd", 16'(bus.bcd_out), 16'h0000);
    chk("reset fs", 16'(bus.frame_start), 16'h0000);
    bus.load = 1'b0;
    rst_n    = 1'b1;

    check_frame("blank0", 16'h0001, 16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    check_frame("blank1", 16'h0001, 16'h0000, 1'b1,  2, 16'h1234, -1, 16'h0, 16);
    check_frame("d1234a", 16'h8421, 16'h1234, 1'b1, -1, 16'h0, -1, 16'h0, 16);
    check_frame("d1234b", 16'h8421, 16'h1234, 1'b1,  5, 16'h0050, -1, 16'h0, 16);
    check_frame("d0050",  16'h0021, 16'h0050, 1'b1,  8, 16'h1111, 13, 16'h2222, 16);
    check_frame("d2222",  16'h8421, 16'h2222, 1'b1, -1, 16'h0, 15, 16'h9876, 16);
    check_frame("d9876a", 16'h8421, 16'h9876, 1'b1, -1, 16'h0, -1, 16'h0, 16);
    check_frame("d9876b", 16'h8421, 16'h9876, 1'b1,  8, 16'h4321, -1, 16'h0, 10);

    // Slot 2, pending 4321 held: reset must clear outputs without a clock.
    rst_n = 1'b0;
    #1;
    chk("midrst en", 16'(bus.digit_en), 16'h0001);
    chk("midrst bcd", 16'(bus.bcd_out), 16'h0000);
    chk("midrst fs", 16'(bus.frame_start), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    check_frame("postrst0", 16'h0001, 16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    check_frame("postrst1", 16'h0001, 16'h0000, 1'b1, -1, 16'h0, -1, 16'h0, 16);
    chk("postrst2 fs", 16'(bus.frame_start), 16'h0001);
    chk("postrst2 en", 16'(bus.digit_en), 16'h0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
